// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register followed by the execute-stage
// operand selection that feeds the ALU.
//
// Captures decoded operands and control every clock (with stall and flush),
// resolves RAW hazards by forwarding from MEM and WB, and drives SrcAE,
// SrcBE and ALUControlE into the ALU.
//
// Build option: define EX_FORWARD_EN to include the MEM/WB forwarding muxes.
// Without it the operands come straight from the E registers (the hazard
// unit is then expected to stall), and the M/W ports are accepted but unused.
module ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallE,
    input  logic               FlushE,
    input  logic [XLEN-1:0]    RD1D,
    input  logic [XLEN-1:0]    RD2D,
    input  logic [XLEN-1:0]    ImmExtD,
    input  logic [XLEN-1:0]    PCD,
    input  logic [RADDR_W-1:0] Rs1D,
    input  logic [RADDR_W-1:0] Rs2D,
    input  logic [RADDR_W-1:0] RdD,
    input  logic [3:0]         ALUControlD,
    input  logic               ALUSrcD,
    input  logic               RegWriteD,
    input  logic               ValidD,
    input  logic [RADDR_W-1:0] RdM,
    input  logic               RegWriteM,
    input  logic [XLEN-1:0]    ALUResultM,
    input  logic [RADDR_W-1:0] RdW,
    input  logic               RegWriteW,
    input  logic [XLEN-1:0]    ResultW,
    output logic [XLEN-1:0]    SrcAE,
    output logic [XLEN-1:0]    SrcBE,
    output logic [3:0]         ALUControlE,
    output logic [XLEN-1:0]    WriteDataE,
    output logic [XLEN-1:0]    PCE,
    output logic [XLEN-1:0]    ImmExtE,
    output logic [RADDR_W-1:0] Rs1E,
    output logic [RADDR_W-1:0] Rs2E,
    output logic [RADDR_W-1:0] RdE,
    output logic               RegWriteE,
    output logic               ValidE
);

    // ALU opcodes whose B operand is a shift amount
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam int         SHAMT_W = 5;

    // All E-side state in one record so flush/reset clear it uniformly
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               alu_src;
        logic [3:0]         alu_ctrl;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    rd1;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
    } e_regs_t;

    e_regs_t e_q;
    e_regs_t e_d;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] sel_b;

    // Next E state: flush beats stall, stall holds, otherwise capture D
    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (!StallE) begin
            e_d.valid     = ValidD;
            e_d.reg_write = RegWriteD & ValidD;
            e_d.alu_src   = ALUSrcD;
            e_d.alu_ctrl  = ALUControlD;
            e_d.rs1       = Rs1D;
            e_d.rs2       = Rs2D;
            e_d.rd        = RdD;
            e_d.rd1       = RD1D;
            e_d.rd2       = RD2D;
            e_d.imm       = ImmExtD;
            e_d.pc        = PCD;
        end
    end

    // ID/EX register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

`ifdef EX_FORWARD_EN
    logic fwd_a_mem;
    logic fwd_a_wb;
    logic fwd_b_mem;
    logic fwd_b_wb;

    // Hazard match: x0 is never a forwarding source
    always_comb begin
        fwd_a_mem = RegWriteM && (RdM != '0) && (RdM == e_q.rs1);
        fwd_a_wb  = RegWriteW && (RdW != '0) && (RdW == e_q.rs1);
        fwd_b_mem = RegWriteM && (RdM != '0) && (RdM == e_q.rs2);
        fwd_b_wb  = RegWriteW && (RdW != '0) && (RdW == e_q.rs2);
    end

    // Forwarding muxes, MEM is younger so it wins over WB
    always_comb begin
        if (fwd_a_mem)     fwd_a = ALUResultM;
        else if (fwd_a_wb) fwd_a = ResultW;
        else               fwd_a = e_q.rd1;

        if (fwd_b_mem)     fwd_b = ALUResultM;
        else if (fwd_b_wb) fwd_b = ResultW;
        else               fwd_b = e_q.rd2;
    end
`else
    logic unused_fwd_ports;

    // No forwarding in this build; M/W inputs are deliberately ignored
    always_comb begin
        fwd_a = e_q.rd1;
        fwd_b = e_q.rd2;
    end

    assign unused_fwd_ports = ^{RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW};
`endif

    // Operand B selection and shift-amount masking
    always_comb begin
        sel_b = e_q.alu_src ? e_q.imm : fwd_b;
        if ((e_q.alu_ctrl == ALU_SLL) || (e_q.alu_ctrl == ALU_SRL) ||
            (e_q.alu_ctrl == ALU_SRA)) begin
            SrcBE = {{(XLEN-SHAMT_W){1'b0}}, sel_b[SHAMT_W-1:0]};
        end else begin
            SrcBE = sel_b;
        end
    end

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign ALUControlE = e_q.alu_ctrl;
    assign PCE         = e_q.pc;
    assign ImmExtE     = e_q.imm;
    assign Rs1E        = e_q.rs1;
    assign Rs2E        = e_q.rs2;
    assign RdE         = e_q.rd;
    assign RegWriteE   = e_q.reg_write;
    assign ValidE      = e_q.valid;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register plus execute-stage operand selection, sitting directly upstream of the execute ALU. It captures decoded operands and control on each clock, with stall and flush support. It resolves RAW hazards by forwarding from MEM and WB, and drives SrcA, SrcB and ALUControl into the ALU each cycle.

Parameters:
XLEN, 32, datapath width.
RADDR_W, 5, register index width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
StallE  in  1  hold all E registers
FlushE  in  1  load a bubble into E
RD1D  in  XLEN  rs1 read data from decode
RD2D  in  XLEN  rs2 read data from decode
ImmExtD  in  XLEN  sign-extended immediate
PCD  in  XLEN  instruction PC
Rs1D, Rs2D, RdD  in  RADDR_W  register indices
ALUControlD  in  4  ALU opcode, same encoding as the ALU (0000 add … 1001 sra)
ALUSrcD  in  1  1 = SrcB takes the immediate
RegWriteD  in  1  instruction writes rd
ValidD  in  1  decode slot holds a real instruction
RdM  in  RADDR_W  MEM-stage destination index
RegWriteM  in  1  MEM-stage write enable
ALUResultM  in  XLEN  MEM-stage result
RdW  in  RADDR_W  WB-stage destination index
RegWriteW  in  1  WB-stage write enable
ResultW  in  XLEN  WB-stage result
SrcAE  out  XLEN  ALU operand A
SrcBE  out  XLEN  ALU operand B
ALUControlE  out  4  registered ALU opcode
WriteDataE  out  XLEN  forwarded rs2 value, used for stores
PCE, ImmExtE  out  XLEN  registered copies
Rs1E, Rs2E, RdE  out  RADDR_W  registered indices, visible to the hazard unit
RegWriteE, ValidE  out  1  registered control bits

Behaviour:
- Reset is asynchronous: all E registers clear to 0 immediately on reset=1, independent of clk.
  - Effect: ValidE=0, RegWriteE=0, ALUControlE=0000 (add), Rs/Rd indices = 0.
  - With zero data and no forwarding match, SrcAE = SrcBE = 0.
- Register update at each rising clk edge, in priority order:
  - reset.
  - FlushE=1: load a bubble. All fields become 0; ValidE=0, RegWriteE=0. FlushE wins over StallE.
  - StallE=1: every E register holds its value.
  - Otherwise: capture all D-side inputs. ValidE=ValidD; RegWriteE=RegWriteD & ValidD.
- Latency: one cycle from a D input to its E register. Forwarding and operand muxing are combinational from the E registers and the M/W inputs.
- Forward select for A (B identical, using Rs2E):
  - MEM: RegWriteM & (RdM != 0) & (RdM == Rs1E).
  - else WB: RegWriteW & (RdW != 0) & (RdW == Rs1E).
  - else: registered RD1E.
  - MEM has priority over WB when both match.
  - Index x0 is never forwarded.
- Operand assembly:
  - SrcAE = forwarded A.
  - WriteDataE = forwarded B.
  - SrcBE = ImmExtE if ALUSrcE=1, else forwarded B.
- Shift-amount masking: when ALUControlE is 0111, 1000 or 1001, SrcBE = {27'b0, selected_B[4:0]}. All other opcodes pass SrcBE unmasked.
- A bubble, or ValidE=0, still drives the operands. Downstream stages qualify on ValidE and RegWriteE only.
- Stalling while M/W change: forwarded operands track the current M/W inputs each cycle, because forwarding is combinational on the held Rs1E/Rs2E.

Optional Feature:
EX_FORWARD_EN
- Defined: forwarding muxes are present as specified above.
- Undefined: SrcAE = RD1E and WriteDataE = RD2E directly. The hazard unit must stall instead. The RdM, RegWriteM, ALUResultM, RdW, RegWriteW and ResultW ports remain present but are ignored.

Test Plan:
1. Reset: assert reset mid-cycle with valid data loaded -> outputs clear to 0 before the next clk edge; ValidE=0, ALUControlE=0000.
2. Normal capture: RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=0000, ValidD=1, RegWriteD=1, no M/W match -> after one clk SrcAE=5, SrcBE=7, RegWriteE=1.
3. Forward priority: Rs1E=3; RdM=3, RegWriteM=1, ALUResultM=0xAA; RdW=3, RegWriteW=1, ResultW=0xBB -> SrcAE=0xAA. Drop RegWriteM -> SrcAE=0xBB. Set RdM=RdW=0, Rs1E=0 -> SrcAE=RD1E.
4. Immediate and store data: ALUSrcD=1, ImmExtD=0xFFFFFFF0, Rs2 forwarded from WB with 0x1234 -> SrcBE=0xFFFFFFF0, WriteDataE=0x1234.
5. Shift mask: ALUControlD=0111, RD2D=0x00000125 -> SrcBE=0x00000005.
6. Stall/flush: StallE=1 for 2 cycles with changing D inputs -> E registers unchanged. StallE=1 and FlushE=1 together -> bubble loaded (ValidE=0, RegWriteE=0).
